// File: rtl/sgt_serial.sv
// Multi-cycle signed set-on-greater-than: scans DIGIT bits per cycle from the MSB end.
// Define SGT_SERIAL_EARLY_EXIT_EN to end the scan on the first differing digit.
module sgt_serial #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sgtout,
  output logic             flag
);

  localparam int N  = WIDTH / DIGIT;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [IW-1:0]    idx_reg;
  logic             done_reg;
  logic             flag_reg;
  logic [WIDTH-1:0] sgtout_reg;

  logic [DIGIT-1:0] a_dig [N];
  logic [DIGIT-1:0] b_dig [N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_dig
      assign a_dig[gi] = a_reg[gi*DIGIT +: DIGIT];
      assign b_dig[gi] = b_reg[gi*DIGIT +: DIGIT];
    end
  endgenerate

  logic [DIGIT-1:0] cur_a, cur_b;
  logic             digit_diff, digit_gt, last_digit, finish, decision;

  assign cur_a      = a_dig[idx_reg];
  assign cur_b      = b_dig[idx_reg];
  assign digit_diff = (cur_a != cur_b);
  assign digit_gt   = (cur_a > cur_b);
  assign last_digit = (idx_reg == '0);

`ifdef SGT_SERIAL_EARLY_EXIT_EN
  assign finish   = digit_diff || last_digit;
  assign decision = digit_diff && digit_gt;
`else
  // Sticky decision from the first differing digit; later digits only burn cycles.
  logic decided_reg, dec_reg;
  assign finish   = last_digit;
  assign decision = decided_reg ? dec_reg : (digit_diff && digit_gt);

  always_ff @(posedge clk) begin
    if (reset) begin
      decided_reg <= 1'b0;
      dec_reg     <= 1'b0;
    end else if (state_reg == IDLE) begin
      decided_reg <= 1'b0;
      dec_reg     <= 1'b0;
    end else if (digit_diff && !decided_reg) begin
      decided_reg <= 1'b1;
      dec_reg     <= digit_gt;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start)  state_next = SCAN;
      SCAN:    if (finish) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_reg == SCAN);
    done   = done_reg;
    sgtout = sgtout_reg;
    flag   = flag_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg      <= '0;
      b_reg      <= '0;
      idx_reg    <= '0;
      done_reg   <= 1'b0;
      sgtout_reg <= '0;
      flag_reg   <= 1'b1;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            // Flipping the sign bit maps signed order onto unsigned order.
            a_reg   <= {~inA[WIDTH-1], inA[WIDTH-2:0]};
            b_reg   <= {~inB[WIDTH-1], inB[WIDTH-2:0]};
            idx_reg <= IW'(N - 1);
          end
        end
        SCAN: begin
          idx_reg <= idx_reg - IW'(1);
          if (finish) begin
            sgtout_reg <= {WIDTH{decision}};
            flag_reg   <= ~decision;
            done_reg   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sgt_serial.sv
// Randomized self-checking bench for sgt_serial against a signed-arithmetic reference model.
module tb_sgt_serial;
  localparam int WIDTH = 32;
  localparam int DIGIT = 4;
  localparam int N     = WIDTH / DIGIT;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] inA, inB;
  logic             busy, done, flag;
  logic [WIDTH-1:0] sgtout;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  sgt_serial #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk(clk), .reset(reset), .start(start), .inA(inA), .inB(inB),
    .busy(busy), .done(done), .sgtout(sgtout), .flag(flag)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Scan steps to completion: position of the highest differing bit, or N when not exiting early.
  function automatic int exp_lat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] x;
    x = a ^ b;
`ifdef SGT_SERIAL_EARLY_EXIT_EN
    for (int i = WIDTH - 1; i >= 0; i--)
      if (x[i]) return N - i / DIGIT;
`endif
    return N;
  endfunction

  // Called at a sampling point (#1 after an edge) with the DUT idle or in its done cycle.
  task automatic op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                    input bit hold, input bit chain);
    bit gt;
    int k, cyc;
    bit got;
    gt = ($signed(a) > $signed(b));
    k  = exp_lat(a, b);
    inA = a; inB = b; start = 1'b1;
    @(posedge clk); #1;
    check("busy_after_accept", busy, 1);
    if (hold) begin inA = $urandom; inB = $urandom; end
    else start = 1'b0;
    cyc = 0; got = 0;
    while (!got && cyc < N + 4) begin
      @(posedge clk); #1;
      cyc++;
      if (done) got = 1;
      else begin
        check("busy_scan", busy, 1);
        if (hold) begin inA = $urandom; inB = $urandom; end
      end
    end
    start = 1'b0;
    check("done_seen", got, 1);
    check("latency", cyc, k);
    check("sgtout", sgtout, gt ? 32'hFFFFFFFF : 32'h0);
    check("flag", flag, !gt);
    check("busy_at_done", busy, 0);
    $display("op a=%h b=%h hold=%0d chain=%0d exp_gt=%0d exp_lat=%0d lat=%0d sgtout=%h flag=%0d",
             a, b, hold, chain, gt, k, cyc, sgtout, flag);
    if (!chain) begin
      @(posedge clk); #1;
      check("done_one_cycle", done, 0);
      check("idle_busy", busy, 0);
      check("hold_sgtout", sgtout, gt ? 32'hFFFFFFFF : 32'h0);
    end
  endtask

  initial begin
    logic [WIDTH-1:0] a, b;
    int seen;
    reset = 1'b1; start = 1'b0; inA = '0; inB = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sgtout", sgtout, 0);
    check("rst_flag", flag, 1);
    reset = 1'b0;
    @(posedge clk); #1;

    op(32'h00000005, 32'h00000003, 0, 0);
    op(32'h80000000, 32'h7FFFFFFF, 0, 0);
    op(32'h10000000, 32'h0FFFFFFF, 0, 0);
    op(32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
    op(32'hFFFFFFFF, 32'hFFFFFFFE, 0, 0);
    op(32'h7FFFFFFF, 32'h80000000, 1, 0);
    op(32'h00000001, 32'h00000002, 0, 1);
    op(32'h00000002, 32'h00000001, 0, 0);

    // Abort mid-scan; equal operands keep the scan running to the full N steps.
    inA = 32'h12345678; inB = 32'h12345678; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("busy_before_abort", busy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sgtout", sgtout, 0);
    check("abort_flag", flag, 1);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < N + 2; i++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("no_done_after_abort", seen, 0);
    op(32'hFFFFFFF0, 32'h0000000F, 0, 0);

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom;
        1:       b = a;
        2:       b = a ^ (32'h1 << $urandom_range(0, 31));
        default: b = {a[31:16], 16'($urandom)};
      endcase
      op(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
